// File: rtl/mult_seq_ctrl.sv
// Control FSM for the 16x9 sequential shift-add multiplier: drives the operand
// loader and accumulator strobes and exposes a START/BUSY/DONE host handshake.
module mult_seq_ctrl #(
  parameter int N_BITS = 9,
  parameter int CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             MY_BIT,
  output logic             LOAD_MX,
  output logic             LOAD_MY,
  output logic             SFT_MY,
  output logic             CLR_ACC,
  output logic             ADD_EN,
  output logic             SFT_ACC,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_BITS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Unused encodings fall through to the default arm and recover to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = START ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIN;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are pure state decodes so a reset drops them without a clock edge.
  always_comb begin
    LOAD_MX = 1'b0;
    LOAD_MY = 1'b0;
    CLR_ACC = 1'b0;
    SFT_MY  = 1'b0;
    SFT_ACC = 1'b0;
    ADD_EN  = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        LOAD_MX = 1'b1;
        LOAD_MY = 1'b1;
        CLR_ACC = 1'b1;
        BUSY    = 1'b1;
      end
      ST_ADD: begin
        ADD_EN = MY_BIT;
        BUSY   = 1'b1;
      end
      ST_SHIFT: begin
        SFT_MY  = 1'b1;
        SFT_ACC = 1'b1;
        BUSY    = 1'b1;
      end
      ST_FIN: begin
        DONE = 1'b1;
        BUSY = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  assign CNT = cnt_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: models the operand loader and accumulator around the
// controller and checks strobe timelines and final products against Mx*My.
module tb_mult_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic       MY_BIT;
  logic       LOAD_MX, LOAD_MY, SFT_MY, CLR_ACC, ADD_EN, SFT_ACC, BUSY, DONE;
  logic [3:0] CNT;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [15:0] mx_in, mx_reg;
  logic [8:0]  my_in, my_sh;
  logic [25:0] acc;

  mult_seq_ctrl #(.N_BITS(9), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MY_BIT(MY_BIT),
    .LOAD_MX(LOAD_MX), .LOAD_MY(LOAD_MY), .SFT_MY(SFT_MY), .CLR_ACC(CLR_ACC),
    .ADD_EN(ADD_EN), .SFT_ACC(SFT_ACC), .BUSY(BUSY), .DONE(DONE), .CNT(CNT)
  );

  always #5 CLK = ~CLK;

  // Loader and accumulator datapath models driven by the controller strobes.
  assign MY_BIT = my_sh[0];
  always @(posedge CLK) begin
    if (LOAD_MX) mx_reg <= mx_in;
    if (LOAD_MY) my_sh <= my_in;
    else if (SFT_MY) my_sh <= my_sh >> 1;
    if (CLR_ACC) acc <= '0;
    else if (ADD_EN) acc <= acc + ({10'b0, mx_reg} << 9);
    else if (SFT_ACC) acc <= acc >> 1;
  end

  function automatic logic [7:0] outs();
    return {LOAD_MX, LOAD_MY, SFT_MY, CLR_ACC, ADD_EN, SFT_ACC, BUSY, DONE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from an IDLE negedge; cycle c=1 is the LOAD cycle.
  // A nonzero pulse_c raises START for one cycle during cycle pulse_c.
  task automatic run_op(input logic [15:0] mx, input logic [8:0] my, input int pulse_c);
    int adds = 0;
    int sfts = 0;
    logic [24:0] prod;
    mx_in = mx;
    my_in = my;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      logic ld, ad, sf, dn, by;
      bit   add_cyc;
      ld      = (c == 1);
      add_cyc = (c >= 2 && c <= 18 && c % 2 == 0);
      ad      = add_cyc ? my[(c - 2) / 2] : 1'b0;
      sf      = (c >= 3 && c <= 19 && c % 2 == 1);
      dn      = (c == 20);
      by      = (c <= 20);
      check($sformatf("strobes mx=%h my=%h c=%0d", mx, my, c), 32'(outs()),
            32'({ld, ld, sf, ld, ad, sf, by, dn}));
      if (add_cyc) check($sformatf("cnt add c=%0d", c), 32'(CNT), 32'((c - 2) / 2));
      if (sf)      check($sformatf("cnt shift c=%0d", c), 32'(CNT), 32'((c - 3) / 2));
      if (dn)      check("cnt fin", 32'(CNT), 32'd8);
      if (ADD_EN) adds++;
      if (SFT_MY) sfts++;
      START = (c == pulse_c);
      @(negedge CLK);
    end
    prod = 25'(mx) * 25'(my);
    check($sformatf("add count my=%h", my), 32'(adds), 32'($countones(my)));
    check("shift count", 32'(sfts), 32'd9);
    check($sformatf("product %h*%h", mx, my), 32'(acc[24:0]), 32'(prod));
    $display("op mx=%h my=%h product=%h expected=%h", mx, my, acc[24:0], prod);
  endtask

  initial begin
    int done_c[$];
    int busy_low;
    bit seen;
    mx_reg = '0;
    my_sh  = '0;
    acc    = '0;
    mx_in  = '0;
    my_in  = '0;
    START  = 1'b0;
    RST_N  = 1'b0;
    #1;
    check("reset outs", 32'(outs()), 32'd0);
    check("reset cnt", 32'(CNT), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("idle outs k=%0d", k), 32'(outs()), 32'd0);
      check($sformatf("idle cnt k=%0d", k), 32'(CNT), 32'd0);
      @(negedge CLK);
    end
    $display("reset and idle phase complete");

    run_op(16'hFFFF, 9'h0A5, 0);
    run_op(16'($urandom), 9'h000, 0);
    run_op(16'($urandom), 9'h1FF, 0);
    run_op(16'($urandom), 9'($urandom), 9);

    // Abort during SHIFT with CNT=4 (cycle 11), reset dropped mid-cycle.
    mx_in = 16'($urandom);
    my_in = 9'($urandom);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    check("abort pre cnt", 32'(CNT), 32'd4);
    check("abort pre sft", 32'(SFT_MY), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    check("abort outs", 32'(outs()), 32'd0);
    check("abort cnt", 32'(CNT), 32'd0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (DONE || BUSY) seen = 1;
      @(negedge CLK);
    end
    check("abort no done", 32'(seen), 32'd0);
    $display("mid-op reset complete");
    run_op(16'($urandom), 9'($urandom), 0);

    // START held high: operations repeat every 21 cycles.
    mx_in = 16'($urandom);
    my_in = 9'($urandom);
    START = 1'b1;
    busy_low = 0;
    @(negedge CLK);
    for (int c = 1; c <= 50; c++) begin
      if (DONE) done_c.push_back(c);
      if (!BUSY && c <= 41) busy_low++;
      @(negedge CLK);
    end
    START = 1'b0;
    check("b2b done count", 32'(done_c.size()), 32'd2);
    if (done_c.size() == 2) begin
      check("b2b first done", 32'(done_c[0]), 32'd20);
      check("b2b spacing", 32'(done_c[1] - done_c[0]), 32'd21);
    end
    check("b2b busy low", 32'(busy_low), 32'd1);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
    end
    check("b2b drain", 32'(seen), 32'd1);
    @(negedge CLK);
    $display("back-to-back phase complete");

    for (int k = 0; k < 4; k++) run_op(16'($urandom), 9'($urandom), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
